// File: rtl/pwm_multi_if.sv
// Register-side bundle for pwm_multi: run/load controls, period/duty/mode/prescale, PWM outputs.
// qn exists only when PWM_DEADTIME_EN is defined.
interface pwm_multi_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int PRE_W    = 8
);
    logic                      en;
    logic                      load;
    logic [WIDTH-1:0]          period;
    logic [CHANNELS*WIDTH-1:0] duty;
    logic                      center;
    logic [PRE_W-1:0]          prescale;
    logic [CHANNELS-1:0]       q;
    logic                      period_start;
`ifdef PWM_DEADTIME_EN
    logic [CHANNELS-1:0]       qn;

    modport master (output en, load, period, duty, center, prescale,
                    input  q, period_start, qn);
    modport slave  (input  en, load, period, duty, center, prescale,
                    output q, period_start, qn);
`else
    modport master (output en, load, period, duty, center, prescale,
                    input  q, period_start);
    modport slave  (input  en, load, period, duty, center, prescale,
                    output q, period_start);
`endif
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM on one shared counter; period, duty, mode and prescale are double-buffered.
// Define PWM_DEADTIME_EN to add complementary qn outputs with DEAD-cycle dead-time insertion.
module pwm_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int PRE_W    = 8
`ifdef PWM_DEADTIME_EN
   ,parameter int DEAD     = 2
`endif
) (
    input logic        clk,
    input logic        rst,
    pwm_multi_if.slave bus
);
    // state | meaning
    // UP    | counter stepping toward TOP (the only state used in edge mode)
    // DOWN  | center mode, counter stepping back toward 0
    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

    dir_t                           dir, dir_nxt;
    logic [PRE_W-1:0]               pre_cnt;
    logic [WIDTH-1:0]               cnt, cnt_nxt;
    logic [WIDTH-1:0]               period_act, period_pend;
    logic [CHANNELS-1:0][WIDTH-1:0] duty_act, duty_pend;
    logic                           center_act, center_pend;
    logic [PRE_W-1:0]               prescale_act, prescale_pend;
    logic                           pending;
    logic                           tick, update;
    logic [CHANNELS-1:0]            cmp, q_raw;

    // Every period ends exactly when the next count would be 0, in both modes,
    // so the update event is simply "tick and next count is zero".
    always_comb begin
        tick    = bus.en && (pre_cnt == prescale_act);
        cnt_nxt = cnt;
        dir_nxt = dir;
        if (center_act) begin
            if (period_act == '0) begin
                cnt_nxt = '0;
            end else if (dir == UP) begin
                if (cnt == period_act) begin
                    cnt_nxt = cnt - WIDTH'(1);
                    dir_nxt = DOWN;
                end else begin
                    cnt_nxt = cnt + WIDTH'(1);
                end
            end else begin
                cnt_nxt = cnt - WIDTH'(1);
            end
            if (cnt_nxt == '0) dir_nxt = UP;
        end else begin
            cnt_nxt = (cnt == period_act) ? '0 : cnt + WIDTH'(1);
        end
        update = tick && (cnt_nxt == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       dir <= UP;
        else if (!bus.en || update)    dir <= UP;
        else if (tick)                 dir <= dir_nxt;
    end

    always_comb begin
        cmp = '0;
        for (int i = 0; i < CHANNELS; i++) cmp[i] = (cnt < duty_act[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt       <= '0;
            cnt           <= '0;
            q_raw         <= '0;
            pending       <= 1'b0;
            period_act    <= '1;
            duty_act      <= '0;
            center_act    <= 1'b0;
            prescale_act  <= '0;
            period_pend   <= '0;
            duty_pend     <= '0;
            center_pend   <= 1'b0;
            prescale_pend <= '0;
        end else if (!bus.en) begin
            pre_cnt <= '0;
            cnt     <= '0;
            q_raw   <= '0;
            // Idle: nothing is running, so loads bypass the buffer.
            if (bus.load) begin
                period_act   <= bus.period;
                duty_act     <= bus.duty;
                center_act   <= bus.center;
                prescale_act <= bus.prescale;
                pending      <= 1'b0;
            end
        end else begin
            q_raw   <= cmp;
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
            if (tick) cnt <= cnt_nxt;
            if (update && bus.load) begin
                period_act   <= bus.period;
                duty_act     <= bus.duty;
                center_act   <= bus.center;
                prescale_act <= bus.prescale;
                pending      <= 1'b0;
            end else if (update && pending) begin
                period_act   <= period_pend;
                duty_act     <= duty_pend;
                center_act   <= center_pend;
                prescale_act <= prescale_pend;
                pending      <= 1'b0;
            end else if (bus.load) begin
                period_pend   <= bus.period;
                duty_pend     <= bus.duty;
                center_pend   <= bus.center;
                prescale_pend <= bus.prescale;
                pending       <= 1'b1;
            end
        end
    end

    assign bus.period_start = update;

`ifdef PWM_DEADTIME_EN
    localparam int DW = (DEAD > 0) ? $clog2(DEAD + 1) : 1;

    logic [CHANNELS-1:0][DW-1:0] dt_hi, dt_lo;
    logic [CHANNELS-1:0]         hi_ok, lo_ok;

    // Each side must have been asserted for DEAD cycles before it may drive;
    // dropping resets its counter, which also swallows pulses shorter than DEAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dt_hi <= '0;
            dt_lo <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!q_raw[i])                  dt_hi[i] <= '0;
                else if (dt_hi[i] != DW'(DEAD)) dt_hi[i] <= dt_hi[i] + DW'(1);
                if (q_raw[i])                   dt_lo[i] <= '0;
                else if (dt_lo[i] != DW'(DEAD)) dt_lo[i] <= dt_lo[i] + DW'(1);
            end
        end
    end

    always_comb begin
        hi_ok = '0;
        lo_ok = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            hi_ok[i] = (dt_hi[i] == DW'(DEAD));
            lo_ok[i] = (dt_lo[i] == DW'(DEAD));
        end
    end

    assign bus.q  = q_raw & hi_ok;
    assign bus.qn = ~q_raw & lo_ok;
`else
    assign bus.q  = q_raw;
`endif

endmodule
